// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   ENABLE/DISABLE     : polarity of pipeline-register enables and flush controls
//   pc_state_t         : sequencer FSM states
//   pipe_ctrl_input_t  : bundled hazard/branch/memory/halt requests
//   pipe_ctrl_output_t : bundled per-stage enables and bubble controls
package pipeline_controller_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        FAULT    = 2'd3
    } pc_state_t;

    typedef struct packed {
        logic stall_req;
        logic branch_taken;
        logic dmem_req;
        logic dmem_ready;
        logic halt_req;
    } pipe_ctrl_input_t;

    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_x;
        logic en_m;
        logic flush_d;
        logic flush_x;
        logic flush_w;
    } pipe_ctrl_output_t;

    // Frozen pipeline: nothing advances, nothing is bubbled.
    function automatic pipe_ctrl_output_t ctrl_frozen();
        pipe_ctrl_output_t c;
        c.en_f    = DISABLE;
        c.en_d    = DISABLE;
        c.en_x    = DISABLE;
        c.en_m    = DISABLE;
        c.flush_d = DISABLE;
        c.flush_x = DISABLE;
        c.flush_w = DISABLE;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter: counts inc cycles and holds at all-ones.
//   clk, reset (sync, active-high), inc : count request
//   count                               : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   Inputs : stall_req (load-use), branch_taken (X), dmem_req/dmem_ready (M),
//            halt_req (W), clk, reset (sync, active-high)
//   Outputs: en_F/D/X/M register enables, flush_D/X/W bubble controls (all
//            combinational from state + inputs), halted, fault (state decodes),
//            stall_cnt / flush_cnt saturating performance counters.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             en_F,
    output logic             en_D,
    output logic             en_X,
    output logic             en_M,
    output logic             flush_D,
    output logic             flush_X,
    output logic             flush_W,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam int unsigned WAIT_LAST = MEM_TIMEOUT - 1;

    pc_state_t         state;
    pc_state_t         state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    pipe_ctrl_input_t  req;
    pipe_ctrl_output_t ctrl;
    logic              mem_stall;
    logic              stall_inc;
    logic              flush_inc;

    assign req.stall_req    = stall_req;
    assign req.branch_taken = branch_taken;
    assign req.dmem_req     = dmem_req;
    assign req.dmem_ready   = dmem_ready;
    assign req.halt_req     = halt_req;

    assign mem_stall = req.dmem_req & ~req.dmem_ready;

    // State and wait-cycle register; wait_cnt = completed wait cycles of the
    // current access, zero whenever no access is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Priority resolution: halt > memory wait > branch flush > load-use stall.
    always_comb begin
        ctrl       = ctrl_frozen();
        state_next = state;
        wait_next  = '0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                if (req.halt_req) begin
                    state_next = HALT;
                end else if (mem_stall) begin
                    ctrl.flush_w = ENABLE;
                    stall_inc    = 1'b1;
                    // The first wait cycle is spent in RUN (wait_cnt 0), so
                    // the compare fires on the edge ending wait cycle MEM_TIMEOUT.
                    if (wait_cnt == WAIT_W'(WAIT_LAST)) begin
                        state_next = FAULT;
                    end else begin
                        state_next = MEM_WAIT;
                        wait_next  = wait_cnt + WAIT_W'(1);
                    end
                end else if (req.branch_taken) begin
                    // D holds a wrong-path instruction, so its stall request is moot.
                    ctrl.en_f    = ENABLE;
                    ctrl.en_d    = ENABLE;
                    ctrl.en_x    = ENABLE;
                    ctrl.en_m    = ENABLE;
                    ctrl.flush_d = ENABLE;
                    ctrl.flush_x = ENABLE;
                    flush_inc    = 1'b1;
                    state_next   = RUN;
                end else if (req.stall_req) begin
                    ctrl.en_x    = ENABLE;
                    ctrl.en_m    = ENABLE;
                    ctrl.flush_x = ENABLE;
                    stall_inc    = 1'b1;
                    state_next   = RUN;
                end else begin
                    ctrl.en_f  = ENABLE;
                    ctrl.en_d  = ENABLE;
                    ctrl.en_x  = ENABLE;
                    ctrl.en_m  = ENABLE;
                    state_next = RUN;
                end
            end
            default: begin
                // HALT and FAULT hold the pipeline frozen until reset.
                state_next = state;
            end
        endcase
    end

    assign en_F    = ctrl.en_f;
    assign en_D    = ctrl.en_d;
    assign en_X    = ctrl.en_x;
    assign en_M    = ctrl.en_m;
    assign flush_D = ctrl.flush_d;
    assign flush_X = ctrl.flush_x;
    assign flush_W = ctrl.flush_w;

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a vector table for single-cycle
// behaviour plus hand sequences for timeout, reset, halt and saturation.
module tb_pipeline_controller;

    localparam logic [6:0] C_RUN   = 7'b1111_000;
    localparam logic [6:0] C_STALL = 7'b0011_010;
    localparam logic [6:0] C_BR    = 7'b1111_110;
    localparam logic [6:0] C_MEMW  = 7'b0000_001;
    localparam logic [6:0] C_FRZ   = 7'b0000_000;
    localparam int         NVEC    = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_req = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0;
    logic        dmem_ready = 1'b0, halt_req = 1'b0;

    logic        en_F, en_D, en_X, en_M, flush_D, flush_X, flush_W, halted, fault;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_en_F, s_en_D, s_en_X, s_en_M, s_flush_D, s_flush_X, s_flush_W;
    logic        s_halted, s_fault;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic [6:0]  ctrl, s_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        stall, branch, dreq, drdy, halt;
        logic [6:0]  ctrl;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    assign ctrl   = {en_F, en_D, en_X, en_M, flush_D, flush_X, flush_W};
    assign s_ctrl = {s_en_F, s_en_D, s_en_X, s_en_M, s_flush_D, s_flush_X, s_flush_W};

    pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .en_F(en_F), .en_D(en_D), .en_X(en_X), .en_M(en_M),
        .flush_D(flush_D), .flush_X(flush_X), .flush_W(flush_W),
        .halted(halted), .fault(fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_controller #(.MEM_TIMEOUT(16), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .en_F(s_en_F), .en_D(s_en_D), .en_X(s_en_X), .en_M(s_en_M),
        .flush_D(s_flush_D), .flush_X(s_flush_X), .flush_W(s_flush_W),
        .halted(s_halted), .fault(s_fault), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic vec_t mk(input logic s, b, q, r, h, input logic [6:0] c,
                                input logic [15:0] sc, fc);
        vec_t v;
        v.stall = s; v.branch = b; v.dreq = q; v.drdy = r; v.halt = h;
        v.ctrl = c; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic s, b, q, r, h);
        stall_req = s; branch_taken = b; dmem_req = q; dmem_ready = r; halt_req = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                stl br req rdy hlt  ctrl     stall  flush
        vecs[0]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        vecs[1]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        vecs[3]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        vecs[4]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd0, 16'd0);
        vecs[5]  = mk(1, 0, 0, 0, 0, C_STALL, 16'd0, 16'd0);
        vecs[6]  = mk(1, 0, 0, 0, 0, C_STALL, 16'd1, 16'd0);
        vecs[7]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd2, 16'd0);
        vecs[8]  = mk(1, 1, 0, 0, 0, C_BR,    16'd2, 16'd0);
        vecs[9]  = mk(0, 0, 0, 0, 0, C_RUN,   16'd2, 16'd1);
        vecs[10] = mk(0, 0, 1, 0, 0, C_MEMW,  16'd2, 16'd1);
        vecs[11] = mk(0, 1, 1, 0, 0, C_MEMW,  16'd3, 16'd1);
        vecs[12] = mk(0, 1, 1, 0, 0, C_MEMW,  16'd4, 16'd1);
        vecs[13] = mk(0, 1, 1, 1, 0, C_BR,    16'd5, 16'd1);
        vecs[14] = mk(0, 0, 0, 0, 0, C_RUN,   16'd5, 16'd2);
        vecs[15] = mk(0, 0, 1, 1, 0, C_RUN,   16'd5, 16'd2);
        vecs[16] = mk(0, 0, 0, 0, 0, C_RUN,   16'd5, 16'd2);
        vecs[17] = mk(1, 0, 1, 0, 0, C_MEMW,  16'd5, 16'd2);
        vecs[18] = mk(1, 0, 1, 1, 0, C_STALL, 16'd6, 16'd2);
        vecs[19] = mk(0, 0, 0, 0, 0, C_RUN,   16'd7, 16'd2);

        tick();
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].branch, vecs[i].dreq, vecs[i].drdy, vecs[i].halt);
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", i), 64'({halted, fault, ctrl}), 64'({2'b00, vecs[i].ctrl}));
            chk($sformatf("vec%0d_cnt", i), 64'({stall_cnt, flush_cnt}), 64'({vecs[i].sc, vecs[i].fc}));
            tick();
        end

        // Timeout: four unanswered wait cycles, then frozen in FAULT.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 0);
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 64'({fault, ctrl}), 64'({1'b0, C_MEMW}));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1, 0);
            @(negedge clk);
            chk($sformatf("to_frozen%0d", k), 64'({halted, fault, ctrl}), 64'({2'b01, C_FRZ}));
            chk($sformatf("to_cnt%0d", k), 64'({stall_cnt, flush_cnt}), 64'({16'd4, 16'd0}));
            tick();
        end
        apply_reset();
        @(negedge clk);
        chk("to_reset", 64'({halted, fault, ctrl, stall_cnt}), 64'({2'b00, C_RUN, 16'd0}));

        // Ready on the last allowed wait cycle: no fault.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 1, 0);
        @(negedge clk);
        chk("edge_ready", 64'({fault, ctrl}), 64'({1'b0, C_RUN}));
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("edge_after", 64'({fault, ctrl, stall_cnt}), 64'({1'b0, C_RUN, 16'd3}));
        tick();

        // Reset during MEM_WAIT returns to RUN with a fresh wait count.
        drive(0, 0, 1, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_wait%0d", k), 64'({fault, ctrl}), 64'({1'b0, C_MEMW}));
            tick();
        end
        drive(0, 0, 1, 1, 0);
        @(negedge clk);
        chk("rst_done", 64'({fault, ctrl, stall_cnt}), 64'({1'b0, C_RUN, 16'd3}));
        tick();

        // Halt during a branch flush: halt wins and is sticky.
        apply_reset();
        drive(0, 1, 0, 0, 1);
        @(negedge clk);
        chk("halt_cycle", 64'({halted, fault, ctrl}), 64'({2'b00, C_FRZ}));
        tick();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("halt_next", 64'({halted, fault, ctrl}), 64'({2'b10, C_FRZ}));
        chk("halt_cnt", 64'({stall_cnt, flush_cnt}), 64'(0));
        tick();
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("halt_sticky", 64'({halted, fault, ctrl}), 64'({2'b10, C_FRZ}));
        tick();

        // Saturation of a 2-bit stall counter.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("sat_ctrl%0d", k), 64'(s_ctrl), 64'(C_STALL));
            chk($sformatf("sat_cnt%0d", k), 64'(s_stall_cnt), 64'((k < 3) ? k : 3));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_final", 64'({s_halted, s_fault, s_flush_cnt, s_stall_cnt}), 64'({4'b0000, 2'd3}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
